// File: rtl/adv_timer_b_counter.sv
// Advanced timer counter: prescaled sawtooth or up-down count with shadowed
// configuration, deferred reload at period end and a synchronised external tick.
module adv_timer_b_counter #(
    parameter int WIDTH       = 16,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_start_i,
    input  logic                   cmd_stop_i,
    input  logic                   cmd_update_i,
    input  logic                   cmd_reset_i,
    input  logic [WIDTH-1:0]       cfg_start_i,
    input  logic [WIDTH-1:0]       cfg_end_i,
    input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
    input  logic                   cfg_updown_i,
    input  logic                   cfg_extsel_i,
    input  logic                   ext_i,
    output logic [WIDTH-1:0]       counter_o,
    output logic                   dir_o,
    output logic                   end_o,
    output logic                   active_o
);

    localparam logic [WIDTH-1:0]       ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESC_WIDTH-1:0] ONE_P = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       counter_q, counter_d;
    logic                   dir_q, dir_d;
    logic                   end_q, end_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic                   pending_q, pending_d;
    logic [WIDTH-1:0]       sh_start_q, sh_start_d, sh_end_q, sh_end_d;
    logic [PRESC_WIDTH-1:0] sh_presc_q, sh_presc_d;
    logic                   sh_updown_q, sh_updown_d, sh_extsel_q, sh_extsel_d;
    logic                   ext_meta_q, ext_sync_q, ext_prev_q;

    logic                   run_s, ext_rise_s, enable_s, tick_s, pend_req_s, load_s;
    logic [WIDTH-1:0]       step_cnt_s;
    logic                   step_dir_s, period_end_s;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stop outranks start, cmd_reset_i never moves the state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start_i && !cmd_stop_i) state_d = ST_RUN;
                else                            state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cmd_stop_i) state_d = ST_IDLE;
                else            state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        run_s = 1'b0;
        case (state_q)
            ST_RUN:  run_s = 1'b1;
            default: run_s = 1'b0;
        endcase
    end

    // ext_i synchroniser plus one delay flop for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            ext_meta_q <= ext_i;
            ext_sync_q <= ext_meta_q;
            ext_prev_q <= ext_sync_q;
        end
    end

    assign ext_rise_s = ext_sync_q & ~ext_prev_q;
    assign enable_s   = run_s & ~cmd_stop_i & (sh_extsel_q ? ext_rise_s : 1'b1);
    assign tick_s     = enable_s & (presc_cnt_q == sh_presc_q);
    assign pend_req_s = cmd_update_i & run_s;

    // Counter value a tick would produce under the current shadow period
    always_comb begin
        step_cnt_s   = counter_q;
        step_dir_s   = dir_q;
        period_end_s = 1'b0;
        if (sh_start_q >= sh_end_q) begin
            step_cnt_s   = sh_start_q;
            step_dir_s   = 1'b0;
            period_end_s = 1'b1;
        end else if (!sh_updown_q) begin
            step_dir_s = 1'b0;
            if (counter_q == sh_end_q) begin
                step_cnt_s   = sh_start_q;
                period_end_s = 1'b1;
            end else begin
                step_cnt_s = counter_q + ONE_W;
            end
        end else if (!dir_q) begin
            if (counter_q == sh_end_q) begin
                step_cnt_s   = sh_end_q - ONE_W;
                step_dir_s   = 1'b1;
                period_end_s = 1'b1;
            end else begin
                step_cnt_s = counter_q + ONE_W;
            end
        end else begin
            if (counter_q == sh_start_q) begin
                step_cnt_s   = sh_start_q + ONE_W;
                step_dir_s   = 1'b0;
                period_end_s = 1'b1;
            end else begin
                step_cnt_s = counter_q - ONE_W;
            end
        end
    end

    // Command priority and tick application; a pending update replaces the wrap/turn
    always_comb begin
        counter_d   = counter_q;
        dir_d       = dir_q;
        end_d       = 1'b0;
        presc_cnt_d = presc_cnt_q;
        pending_d   = pending_q | pend_req_s;
        load_s      = 1'b0;
        if (cmd_reset_i) begin
            counter_d   = sh_start_q;
            dir_d       = 1'b0;
            presc_cnt_d = '0;
        end else if (cmd_update_i && !run_s) begin
            load_s      = 1'b1;
            counter_d   = cfg_start_i;
            dir_d       = 1'b0;
            presc_cnt_d = '0;
            pending_d   = 1'b0;
        end else if (tick_s && period_end_s && pending_q) begin
            load_s      = 1'b1;
            counter_d   = cfg_start_i;
            dir_d       = 1'b0;
            end_d       = 1'b1;
            presc_cnt_d = '0;
            pending_d   = 1'b0;
        end else if (tick_s) begin
            counter_d   = step_cnt_s;
            dir_d       = step_dir_s;
            end_d       = period_end_s;
            presc_cnt_d = '0;
        end else if (enable_s) begin
            presc_cnt_d = presc_cnt_q + ONE_P;
        end else begin
            presc_cnt_d = presc_cnt_q;
        end
    end

    // Shadow configuration next state
    always_comb begin
        if (load_s) begin
            sh_start_d  = cfg_start_i;
            sh_end_d    = cfg_end_i;
            sh_presc_d  = cfg_presc_i;
            sh_updown_d = cfg_updown_i;
            sh_extsel_d = cfg_extsel_i;
        end else begin
            sh_start_d  = sh_start_q;
            sh_end_d    = sh_end_q;
            sh_presc_d  = sh_presc_q;
            sh_updown_d = sh_updown_q;
            sh_extsel_d = sh_extsel_q;
        end
    end

    // Datapath and shadow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q   <= '0;
            dir_q       <= 1'b0;
            end_q       <= 1'b0;
            presc_cnt_q <= '0;
            pending_q   <= 1'b0;
            sh_start_q  <= '0;
            sh_end_q    <= '0;
            sh_presc_q  <= '0;
            sh_updown_q <= 1'b0;
            sh_extsel_q <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            dir_q       <= dir_d;
            end_q       <= end_d;
            presc_cnt_q <= presc_cnt_d;
            pending_q   <= pending_d;
            sh_start_q  <= sh_start_d;
            sh_end_q    <= sh_end_d;
            sh_presc_q  <= sh_presc_d;
            sh_updown_q <= sh_updown_d;
            sh_extsel_q <= sh_extsel_d;
        end
    end

    assign counter_o = counter_q;
    assign dir_o     = dir_q;
    assign end_o     = end_q;
    assign active_o  = run_s;

endmodule

// File: tb/tb_adv_timer_b_counter.sv
// Testbench for adv_timer_b_counter: directed scenarios plus random commands,
// all checked every cycle against a position-based behavioural model.
module tb_adv_timer_b_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start_i, cmd_stop_i, cmd_update_i, cmd_reset_i;
    logic [15:0] cfg_start_i, cfg_end_i;
    logic [7:0]  cfg_presc_i;
    logic        cfg_updown_i, cfg_extsel_i, ext_i;
    logic [15:0] counter_o;
    logic        dir_o, end_o, active_o;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int       m_cnt, m_pc, s_start, s_end, s_presc;
    bit       m_dir, m_end, m_act, m_pend, s_ud, s_ext;
    bit [2:0] hist;

    int exp_saw[5]  = '{3, 4, 5, 2, 3};
    int exp_saw_e[5] = '{0, 0, 0, 1, 0};
    int exp_ud[14]   = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1};
    int exp_ud_d[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    int exp_ud_e[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    int exp_upd[9]   = '{7, 8, 9, 0, 1, 2, 3, 4, 0};
    int exp_upd_e[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};

    adv_timer_b_counter #(.WIDTH(16), .PRESC_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_start_i  (cmd_start_i),
        .cmd_stop_i   (cmd_stop_i),
        .cmd_update_i (cmd_update_i),
        .cmd_reset_i  (cmd_reset_i),
        .cfg_start_i  (cfg_start_i),
        .cfg_end_i    (cfg_end_i),
        .cfg_presc_i  (cfg_presc_i),
        .cfg_updown_i (cfg_updown_i),
        .cfg_extsel_i (cfg_extsel_i),
        .ext_i        (ext_i),
        .counter_o    (counter_o),
        .dir_o        (dir_o),
        .end_o        (end_o),
        .active_o     (active_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pc = 0; m_dir = 0; m_end = 0; m_act = 0; m_pend = 0;
        s_start = 0; s_end = 0; s_presc = 0; s_ud = 0; s_ext = 0;
        hist = 3'b000;
    endtask

    task automatic load_shadow();
        s_start = int'(cfg_start_i); s_end = int'(cfg_end_i); s_presc = int'(cfg_presc_i);
        s_ud = cfg_updown_i; s_ext = cfg_extsel_i;
    endtask

    // Counter as a position along the period: 0..D for sawtooth, 0..2D for up-down
    task automatic model_tick(input bit upd_run);
        int lo, hi, d, pos, np;
        bit pe;
        lo = s_start; hi = s_end; pe = 0;
        if (lo >= hi) begin
            m_cnt = lo; m_dir = 0; pe = 1;
        end else begin
            d = hi - lo;
            if (!s_ud) begin
                np = (m_cnt - lo + 1) % (d + 1);
                pe = (np == 0); m_cnt = lo + np; m_dir = 0;
            end else begin
                pos = m_dir ? (2 * d - (m_cnt - lo)) : (m_cnt - lo);
                np = (pos == 2 * d) ? 1 : pos + 1;
                pe = (np == d + 1) || (pos == 2 * d);
                m_cnt = (np <= d) ? lo + np : lo + 2 * d - np;
                m_dir = (np > d);
            end
        end
        m_end = pe;
        if (pe && m_pend) begin
            load_shadow(); m_cnt = s_start; m_dir = 0; m_pend = 0;
        end else if (upd_run) begin
            m_pend = 1;
        end
    endtask

    task automatic model_next();
        bit upd_run, en, tk, rise, nxt_act;
        rise = hist[1] && !hist[2];
        upd_run = cmd_update_i && m_act;
        nxt_act = cmd_stop_i ? 1'b0 : (cmd_start_i ? 1'b1 : m_act);
        m_end = 0;
        if (cmd_reset_i) begin
            m_cnt = s_start; m_pc = 0; m_dir = 0;
            if (upd_run) m_pend = 1;
        end else if (cmd_update_i && !m_act) begin
            load_shadow(); m_cnt = s_start; m_dir = 0; m_pc = 0; m_pend = 0;
        end else begin
            en = m_act && !cmd_stop_i && (s_ext ? rise : 1'b1);
            tk = 0;
            if (en) begin
                if (m_pc == s_presc) begin m_pc = 0; tk = 1; end
                else m_pc++;
            end
            if (tk) model_tick(upd_run);
            else if (upd_run) m_pend = 1;
        end
        m_act = nxt_act;
        hist = {hist[1:0], ext_i};
    endtask

    task automatic compare_all();
        check_val("counter", 32'(counter_o), m_cnt);
        check_val("dir", 32'(dir_o), 32'(m_dir));
        check_val("end", 32'(end_o), 32'(m_end));
        check_val("active", 32'(active_o), 32'(m_act));
    endtask

    // One clock: model consumes current inputs, DUT output sampled at the falling edge
    task automatic step();
        if (reset) model_reset();
        else model_next();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_cfg(input int st, input int en, input int pr, input bit ud, input bit ex);
        cfg_start_i = 16'(st); cfg_end_i = 16'(en); cfg_presc_i = 8'(pr);
        cfg_updown_i = ud; cfg_extsel_i = ex;
    endtask

    task automatic pulse_update();
        cmd_update_i = 1'b1; step(); cmd_update_i = 1'b0;
    endtask

    task automatic pulse_start();
        cmd_start_i = 1'b1; step(); cmd_start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop_i = 1'b1; step(); cmd_stop_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmd_start_i = 1'b0; cmd_stop_i = 1'b0; cmd_update_i = 1'b0; cmd_reset_i = 1'b0;
        ext_i = 1'b0;
        set_cfg(0, 0, 0, 1'b0, 1'b0);
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        step();

        // Sawtooth 2..5
        set_cfg(2, 5, 0, 1'b0, 1'b0);
        pulse_update();
        pulse_start();
        check_val("saw_hold_after_start", 32'(counter_o), 32'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("saw_seq", 32'(counter_o), exp_saw[i]);
            check_val("saw_end", 32'(end_o), exp_saw_e[i]);
        end

        // Up-down 0..3, prescaler 1
        pulse_stop();
        set_cfg(0, 3, 1, 1'b1, 1'b0);
        pulse_update();
        pulse_start();
        for (int i = 0; i < 14; i++) begin
            step();
            check_val("ud_seq", 32'(counter_o), exp_ud[i]);
            check_val("ud_dir", 32'(dir_o), exp_ud_d[i]);
            check_val("ud_end", 32'(end_o), exp_ud_e[i]);
        end

        // Update mid-run: end 9 -> 4 requested at counter 6
        pulse_stop();
        set_cfg(0, 9, 0, 1'b0, 1'b0);
        pulse_update();
        pulse_start();
        repeat (6) step();
        check_val("upd_pre", 32'(counter_o), 32'd6);
        cfg_end_i = 16'd4;
        cmd_update_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            cmd_update_i = 1'b0;
            check_val("upd_seq", 32'(counter_o), exp_upd[i]);
            check_val("upd_end", 32'(end_o), exp_upd_e[i]);
        end

        // Reset and stop together at counter == end
        repeat (4) step();
        check_val("prio_pre", 32'(counter_o), 32'd4);
        cmd_reset_i = 1'b1; cmd_stop_i = 1'b1;
        step();
        cmd_reset_i = 1'b0; cmd_stop_i = 1'b0;
        check_val("prio_cnt", 32'(counter_o), 32'd0);
        check_val("prio_act", 32'(active_o), 32'd0);
        check_val("prio_end", 32'(end_o), 32'd0);

        // External ticks: 4 pulses, 3 cycles wide, 10 cycles apart
        set_cfg(0, 100, 0, 1'b0, 1'b1);
        pulse_update();
        pulse_start();
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 10; j++) begin
                ext_i = (j < 3);
                step();
                if (j == 1) check_val("ext_before", 32'(counter_o), p);
                if (j == 2) check_val("ext_after", 32'(counter_o), p + 1);
            end
        end
        check_val("ext_total", 32'(counter_o), 32'd4);

        // Asynchronous reset mid-count
        set_cfg(3, 50, 0, 1'b0, 1'b0);
        pulse_stop();
        pulse_update();
        pulse_start();
        repeat (5) step();
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all();
        check_val("areset_cnt", 32'(counter_o), 32'd0);
        #1 reset = 1'b0;

        // Degenerate period start == end == 7
        set_cfg(7, 7, 0, 1'b0, 1'b0);
        pulse_update();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("degen_cnt", 32'(counter_o), 32'd7);
            check_val("degen_end", 32'(end_o), 32'd1);
        end

        // Random commands, configuration and ext_i
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            cmd_start_i  = (r < 4);
            cmd_stop_i   = (r >= 4 && r < 7);
            cmd_reset_i  = (r >= 7 && r < 9);
            cmd_update_i = (r >= 9 && r < 14);
            if ($urandom_range(0, 9) == 0)
                set_cfg($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
            if ($urandom_range(0, 3) == 0) ext_i = ~ext_i;
            step();
        end
        cmd_start_i = 1'b0; cmd_stop_i = 1'b0; cmd_reset_i = 1'b0; cmd_update_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
